// File: rtl/wallace_tree_4_if.sv
// wallace_tree_4_if
// Bundles the operand/result signals of the 4x4 Wallace-tree multiplier.
//   A         [3:0]  unsigned multiplicand        (master -> slave)
//   B         [3:0]  unsigned multiplier          (master -> slave)
//   in_valid         A/B qualified for capture    (master -> slave)
//   M_OUT     [7:0]  registered product A*B       (slave -> master)
//   out_valid        M_OUT holds a fresh product  (slave -> master)
// The clock and reset are kept as plain ports on the multiplier itself.
interface wallace_tree_4_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       in_valid;
  logic [7:0] M_OUT;
  logic       out_valid;

  modport master (
    output A,
    output B,
    output in_valid,
    input  M_OUT,
    input  out_valid
  );

  modport slave (
    input  A,
    input  B,
    input  in_valid,
    output M_OUT,
    output out_valid
  );
endinterface

// File: rtl/wallace_tree_4.sv
// wallace_tree_4
// Unsigned 4x4 multiplier. The 16 partial products are reduced by a
// two-stage Wallace tree of half/full adders down to two rows, which a
// ripple-carry adder sums into the 8-bit product. The product is
// registered once, so a result appears one clock after an in_valid edge,
// with a throughput of one product per clock.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset; clears M_OUT and out_valid
//   bus    wallace_tree_4_if.slave (A, B, in_valid in; M_OUT, out_valid out)
module wallace_tree_4 (
  input  logic                   clk,
  input  logic                   rst_n,
  wallace_tree_4_if.slave        bus
);

  // Returns {carry, sum}.
  function automatic logic [1:0] ha(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  // Returns {carry, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // pp[i][j] = A[j] & B[i], weight 2^(i+j)
  logic [3:0] pp [4];

  // Stage 1 adder outputs ({carry, sum}), named by column
  logic [1:0] s1_c1, s1_c2, s1_c3, s1_c4, s1_c5;
  // Stage 2 adder outputs ({carry, sum}), named by column
  logic [1:0] s2_c2, s2_c3, s2_c4, s2_c5, s2_c6;

  logic [7:0] row0;
  logic [7:0] row1;
  logic [7:0] product;
  logic [7:0] carry;

  logic [7:0] m_out_q, m_out_d;
  logic       out_valid_q, out_valid_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = bus.A[j] & bus.B[i];
      end
    end
  end

  // Stage 1 column heights are 1,2,3,4,3,2,1. Each column is split into
  // groups of three (full adder) and a leftover pair (half adder); a single
  // leftover bit passes through. Column 3 leaves pp[3][0] untouched.
  always_comb begin
    s1_c1 = ha(pp[0][1], pp[1][0]);
    s1_c2 = fa(pp[0][2], pp[1][1], pp[2][0]);
    s1_c3 = fa(pp[0][3], pp[1][2], pp[2][1]);
    s1_c4 = fa(pp[1][3], pp[2][2], pp[3][1]);
    s1_c5 = ha(pp[2][3], pp[3][2]);
  end

  // Stage 2 column heights are 1,1,2,3,2,2,2. Column 3 is the only one still
  // above two; the same grouping rule is applied to every column of height
  // two or more, which leaves every column at height two or less.
  always_comb begin
    s2_c2 = ha(s1_c2[0], s1_c1[1]);
    s2_c3 = fa(s1_c3[0], pp[3][0], s1_c2[1]);
    s2_c4 = ha(s1_c4[0], s1_c3[1]);
    s2_c5 = ha(s1_c5[0], s1_c4[1]);
    s2_c6 = ha(pp[3][3], s1_c5[1]);
  end

  // Gather the two surviving rows for the carry-propagate adder.
  always_comb begin
    row0 = {s2_c6[1], s2_c6[0], s2_c5[0], s2_c4[0], s2_c3[0], s2_c2[0],
            s1_c1[0], pp[0][0]};
    row1 = {1'b0, s2_c5[1], s2_c4[1], s2_c3[1], s2_c2[1], 3'b000};
  end

  // Ripple-carry adder. The carry out of bit 7 is never formed: the largest
  // product is 15*15 = 225, which fits in 8 bits, so it is always zero.
  always_comb begin
    logic [1:0] cs;
    product  = '0;
    carry    = '0;
    cs       = '0;
    for (int k = 0; k < 7; k++) begin
      cs           = fa(row0[k], row1[k], carry[k]);
      product[k]   = cs[0];
      carry[k+1]   = cs[1];
    end
    product[7] = row0[7] ^ row1[7] ^ carry[7];
  end

  // Capture a product only on qualified edges; otherwise hold the last
  // product and drop out_valid so downstream sees it is not new.
  always_comb begin
    m_out_d     = m_out_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      m_out_d     = product;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out_q     <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      m_out_q     <= m_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.M_OUT     = m_out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_wallace_tree_4.sv
// tb_wallace_tree_4
// Directed self-checking bench for wallace_tree_4: reset behaviour, corner
// operands, exhaustive 16x16 sweep, hold, asynchronous reset mid-stream,
// release and back-to-back throughput. Inputs change on the falling edge;
// outputs are sampled 1 ns after the rising edge.
module tb_wallace_tree_4;

  logic clk;
  logic rst_n;
  int   assert_count;
  int   fail_count;

  wallace_tree_4_if bus ();

  wallace_tree_4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set operands on the falling edge so they are stable at the next rising edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic v);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = v;
  endtask

  task automatic tickClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp_m, input logic exp_v);
    assert_count++;
    assert (bus.M_OUT === exp_m) else begin
      fail_count++;
      $error("[TB] FAIL %s M_OUT: observed %0d expected %0d", tag, bus.M_OUT, exp_m);
    end
    assert_count++;
    assert (bus.out_valid === exp_v) else begin
      fail_count++;
      $error("[TB] FAIL %s out_valid: observed %0b expected %0b", tag, bus.out_valid, exp_v);
    end
  endtask

  initial begin
    logic [3:0] corner_a [5];
    logic [3:0] corner_b [5];
    logic [7:0] corner_p [5];

    corner_a = '{4'd0, 4'd15, 4'd1,  4'd15,   4'd8};
    corner_b = '{4'd0, 4'd0,  4'd15, 4'd15,   4'd8};
    corner_p = '{8'd0, 8'd0,  8'd15, 8'hE1,   8'd64};

    assert_count = 0;
    fail_count   = 0;
    rst_n        = 1'b0;
    bus.A        = 4'd0;
    bus.B        = 4'd0;
    bus.in_valid = 1'b0;

    // Reset state before any clock edge
    #2;
    checkOutput("reset_initial", 8'd0, 1'b0);

    // in_valid ignored while reset is held
    applyStimulus(4'd15, 4'd15, 1'b1);
    tickClock();
    checkOutput("reset_held", 8'd0, 1'b0);

    // Release with in_valid low: nothing captured
    applyStimulus(4'd15, 4'd15, 1'b0);
    rst_n = 1'b1;
    tickClock();
    checkOutput("release_idle", 8'd0, 1'b0);

    // Corner operands
    for (int k = 0; k < 5; k++) begin
      applyStimulus(corner_a[k], corner_b[k], 1'b1);
      tickClock();
      checkOutput($sformatf("corner %0d*%0d", corner_a[k], corner_b[k]), corner_p[k], 1'b1);
    end

    // Exhaustive sweep on consecutive edges
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        applyStimulus(4'(i), 4'(j), 1'b1);
        tickClock();
        checkOutput($sformatf("exh %0d*%0d", i, j), 8'(i * j), 1'b1);
      end
    end

    // Hold: capture 7*9, then operands change without in_valid
    applyStimulus(4'd7, 4'd9, 1'b1);
    tickClock();
    checkOutput("hold_capture", 8'd63, 1'b1);
    bus.A = 4'd2;
    bus.B = 4'd2;
    #2;
    checkOutput("hold_midcycle", 8'd63, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'd3, 4'd3, 1'b0);
      tickClock();
      checkOutput($sformatf("hold_cycle%0d", k), 8'd63, 1'b0);
    end

    // Asynchronous reset between edges after 225 is captured
    applyStimulus(4'd15, 4'd15, 1'b1);
    tickClock();
    checkOutput("pre_async", 8'hE1, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'd0, 1'b0);
    tickClock();
    checkOutput("async_reset_held", 8'd0, 1'b0);

    // Release straight into a capture
    applyStimulus(4'd12, 4'd13, 1'b1);
    rst_n = 1'b1;
    tickClock();
    checkOutput("release_12x13", 8'd156, 1'b1);

    // Back-to-back stream
    applyStimulus(4'd2, 4'd3, 1'b1);
    tickClock();
    checkOutput("stream_2x3", 8'd6, 1'b1);
    applyStimulus(4'd5, 4'd5, 1'b1);
    tickClock();
    checkOutput("stream_5x5", 8'd25, 1'b1);
    applyStimulus(4'd15, 4'd14, 1'b1);
    tickClock();
    checkOutput("stream_15x14", 8'd210, 1'b1);
    applyStimulus(4'd1, 4'd1, 1'b0);
    tickClock();
    checkOutput("stream_end_hold", 8'd210, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
